// File: rtl/snake_body_tracker.sv
// Snake body list: one-tile moves per tick, growth, wall and self hits.
// Self hits are found by a serial scan over the body, one slot per cycle.
module snake_body_tracker #(
  parameter int MAX_LEN = 100,
  parameter int GRID_W  = 10,
  parameter int GRID_H  = 10
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic                   step,
  input  logic [1:0]             dir,
  input  logic                   grow,
  output logic [32*MAX_LEN-1:0]  x_values,
  output logic [32*MAX_LEN-1:0]  y_values,
  output logic [7:0]             length,
  output logic                   busy,
  output logic                   moved,
  output logic                   game_done
);

  localparam int IW = $clog2(MAX_LEN);
  localparam logic [7:0] MAX_L8 = 8'(MAX_LEN);

  typedef enum logic [2:0] {
    IDLE, RUN, SCAN, COMMIT, DEAD
  } state_t;

  state_t state, state_nx;

  logic [31:0]   xs [MAX_LEN];
  logic [31:0]   ys [MAX_LEN];
  logic [31:0]   nh_x, nh_y;
  logic [31:0]   cand_x, cand_y;
  logic [1:0]    cur_dir, dir_eff;
  logic          grow_pending, grow_now;
  logic [IW-1:0] k;
  logic [7:0]    k_last;
  logic          wall, hit, scan_done;

  function automatic logic [31:0] init_x(input int i);
    case (i)
      0:       return 32'd4;
      1:       return 32'd3;
      2:       return 32'd2;
      default: return '1;
    endcase
  endfunction

  function automatic logic [31:0] init_y(input int i);
    return (i < 3) ? 32'd5 : '1;
  endfunction

  // A reversal request keeps the current heading.
  assign dir_eff  = (dir == (cur_dir ^ 2'd2)) ? cur_dir : dir;
  assign grow_now = grow_pending | grow;

  always_comb begin
    cand_x = xs[0];
    cand_y = ys[0];
    unique case (dir_eff)
      2'd0: cand_y = ys[0] - 32'd1;
      2'd1: cand_x = xs[0] + 32'd1;
      2'd2: cand_y = ys[0] + 32'd1;
      2'd3: cand_x = xs[0] - 32'd1;
    endcase
  end

  // Unsigned compare also rejects 0 - 1 = 32'hFFFFFFFF.
  assign wall = (cand_x >= 32'(GRID_W))
             || (cand_y >= 32'(GRID_H));
  assign hit  = (xs[k] == nh_x) && (ys[k] == nh_y);
  assign scan_done = (8'(k) == k_last);

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE, DEAD: if (start) state_nx = RUN;
      RUN:        if (step) state_nx = wall ? DEAD : SCAN;
      SCAN: begin
        if (hit)            state_nx = DEAD;
        else if (scan_done) state_nx = COMMIT;
      end
      COMMIT:     state_nx = RUN;
      default:    state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < MAX_LEN; i++) begin
        xs[i] <= init_x(i);
        ys[i] <= init_y(i);
      end
      length       <= 8'd3;
      cur_dir      <= 2'd1;
      grow_pending <= 1'b0;
      moved        <= 1'b0;
      nh_x         <= '0;
      nh_y         <= '0;
      k            <= '0;
      k_last       <= '0;
    end else begin
      moved <= 1'b0;
      if (grow && state != IDLE && state != DEAD)
        grow_pending <= 1'b1;
      unique case (state)
        IDLE, DEAD: begin
          if (start) begin
            for (int i = 0; i < MAX_LEN; i++) begin
              xs[i] <= init_x(i);
              ys[i] <= init_y(i);
            end
            length       <= 8'd3;
            cur_dir      <= 2'd1;
            grow_pending <= 1'b0;
          end
        end
        RUN: begin
          if (step) begin
            cur_dir <= dir_eff;
            nh_x    <= cand_x;
            nh_y    <= cand_y;
            k       <= '0;
            // Without growth the tail vacates, so it is not scanned.
            k_last  <= grow_now ? length - 8'd1
                                : length - 8'd2;
          end
        end
        SCAN: k <= k + IW'(1);
        COMMIT: begin
          for (int i = MAX_LEN - 1; i > 0; i--) begin
            xs[i] <= xs[i-1];
            ys[i] <= ys[i-1];
          end
          xs[0] <= nh_x;
          ys[0] <= nh_y;
          if (grow_now && length < MAX_L8) begin
            length <= length + 8'd1;
          end else begin
            for (int i = 1; i < MAX_LEN; i++) begin
              if (i == int'(length)) begin
                xs[i] <= '1;
                ys[i] <= '1;
              end
            end
          end
          grow_pending <= 1'b0;
          moved        <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    x_values = '0;
    y_values = '0;
    for (int i = 0; i < MAX_LEN; i++) begin
      x_values[32*i +: 32] = xs[i];
      y_values[32*i +: 32] = ys[i];
    end
  end

  assign busy      = (state == SCAN) || (state == COMMIT);
  assign game_done = (state == DEAD);

endmodule

// File: tb/tb_snake_body_tracker.sv
// Bench for snake_body_tracker: a list model predicts each move and
// a scoreboard queue holds the expected outcome until the DUT reports.
module tb_snake_body_tracker;

  localparam int MAX_LEN = 100;
  localparam int GRID_W  = 10;
  localparam int GRID_H  = 10;

  logic clk = 1'b0;
  logic reset, start, step, grow;
  logic [1:0] dir;
  logic [32*MAX_LEN-1:0] x_values, y_values;
  logic [7:0] length;
  logic busy, moved, game_done;

  always #5 clk = ~clk;

  snake_body_tracker #(
    .MAX_LEN(MAX_LEN),
    .GRID_W (GRID_W),
    .GRID_H (GRID_H)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .step     (step),
    .dir      (dir),
    .grow     (grow),
    .x_values (x_values),
    .y_values (y_values),
    .length   (length),
    .busy     (busy),
    .moved    (moved),
    .game_done(game_done)
  );

  typedef struct {
    bit dead;
    int n;
    int bc;
    int len;
  } exp_t;

  exp_t sb[$];

  logic [31:0] mx [MAX_LEN];
  logic [31:0] my [MAX_LEN];
  int          mlen;
  logic [1:0]  mdir;
  bit          mgrow;
  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_init();
    for (int i = 0; i < MAX_LEN; i++) begin
      mx[i] = '1;
      my[i] = '1;
    end
    mx[0] = 4; mx[1] = 3; mx[2] = 2;
    my[0] = 5; my[1] = 5; my[2] = 5;
    mlen  = 3;
    mdir  = 2'd1;
    mgrow = 1'b0;
  endtask

  task automatic chk_body(input string tag);
    chk({tag, "_len"}, 32'(length), mlen);
    for (int i = 0; i < MAX_LEN; i++) begin
      chk($sformatf("%s_x%0d", tag, i), x_values[32*i +: 32], mx[i]);
      chk($sformatf("%s_y%0d", tag, i), y_values[32*i +: 32], my[i]);
    end
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
    model_init();
    chk("start_done", 32'(game_done), 0);
    chk("start_busy", 32'(busy), 0);
    chk_body("start");
  endtask

  task automatic do_step(input logic [1:0] d, input bit g_before,
                         input bit g_during, input bit with_start);
    exp_t e, got;
    logic [1:0]  de;
    logic [31:0] hx, hy;
    int klim, hit, n, bc;
    if (g_before) begin
      grow = 1'b1;
      tick();
      grow = 1'b0;
      mgrow = 1'b1;
    end
    de = (d == (mdir ^ 2'd2)) ? mdir : d;
    mdir = de;
    hx = mx[0];
    hy = my[0];
    case (de)
      2'd0: hy = hy - 1;
      2'd1: hx = hx + 1;
      2'd2: hy = hy + 1;
      default: hx = hx - 1;
    endcase
    e.dead = 1'b0;
    if (hx >= GRID_W || hy >= GRID_H) begin
      e.dead = 1'b1; e.n = 0; e.bc = 0;
    end else begin
      klim = mgrow ? mlen : mlen - 1;
      hit = -1;
      for (int i = 0; i < klim; i++)
        if (hit < 0 && mx[i] == hx && my[i] == hy) hit = i;
      if (hit >= 0) begin
        e.dead = 1'b1; e.n = hit + 1; e.bc = hit + 1;
      end else begin
        if (g_during) mgrow = 1'b1;
        for (int i = MAX_LEN - 1; i > 0; i--) begin
          mx[i] = mx[i-1];
          my[i] = my[i-1];
        end
        mx[0] = hx;
        my[0] = hy;
        if (mgrow && mlen < MAX_LEN) mlen++;
        else if (mlen < MAX_LEN) begin
          mx[mlen] = '1;
          my[mlen] = '1;
        end
        mgrow = 1'b0;
        e.n = klim + 1;
        e.bc = klim + 1;
      end
    end
    e.len = mlen;
    sb.push_back(e);

    step = 1'b1; dir = d; start = with_start;
    tick();
    step = 1'b0; start = 1'b0; grow = g_during;
    n = 0; bc = 0;
    while (!(game_done || moved) && n < 400) begin
      if (busy) bc++;
      tick();
      grow = 1'b0;
      n++;
    end
    grow = 1'b0;
    got = sb.pop_front();
    chk("mv_done", 32'(game_done), 32'(got.dead));
    chk("mv_lat", n, got.n);
    chk("mv_busy", bc, got.bc);
    chk("mv_len", 32'(length), got.len);
    chk_body("mv");
    if (!got.dead) begin
      tick();
      chk("moved_pulse", 32'(moved), 0);
    end
  endtask

  function automatic logic [1:0] tour_dir(input int x, input int y);
    if (x == 0) return (y < 9) ? 2'd2 : 2'd1;
    if (y % 2 == 1) return (x < 9) ? 2'd1 : 2'd0;
    if (x > 1) return 2'd3;
    return (y == 0) ? 2'd3 : 2'd0;
  endfunction

  task automatic restart();
    reset = 1'b1;
    #2;
    reset = 1'b0;
    tick();
    do_start();
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; step = 1'b0;
    grow = 1'b0; dir = 2'd0;
    model_init();
    #3;
    chk("rst_busy", 32'(busy), 0);
    chk("rst_moved", 32'(moved), 0);
    chk("rst_done", 32'(game_done), 0);
    chk_body("rst");
    tick();
    reset = 1'b0;
    tick();

    do_start();
    do_step(2'd1, 0, 0, 0);
    chk("first_x0", x_values[31:0], 5);
    chk("first_x3", x_values[127:96], 32'hFFFFFFFF);

    restart();
    do_step(2'd1, 1, 0, 0);
    chk("grow_len", 32'(length), 4);
    chk("grow_x3", x_values[127:96], 2);

    restart();
    do_step(2'd3, 0, 0, 1);
    chk("rev_x0", x_values[31:0], 5);
    repeat (4) do_step(2'd1, 0, 0, 0);
    chk("wall_x9", x_values[31:0], 9);
    do_step(2'd1, 0, 0, 0);
    step = 1'b1;
    tick();
    step = 1'b0;
    tick();
    chk("dead_done", 32'(game_done), 1);
    chk("dead_busy", 32'(busy), 0);
    chk_body("dead");
    do_start();

    do_step(2'd1, 1, 0, 0);
    do_step(2'd1, 1, 0, 0);
    do_step(2'd2, 0, 0, 0);
    do_step(2'd3, 0, 0, 0);
    do_step(2'd0, 0, 0, 0);
    chk("self_done", 32'(game_done), 1);
    chk("self_len", 32'(length), 5);

    do_start();
    step = 1'b1; dir = 2'd1;
    tick();
    step = 1'b0;
    chk("scan_busy", 32'(busy), 1);
    #2;
    reset = 1'b1;
    #1;
    model_init();
    chk("arst_busy", 32'(busy), 0);
    chk("arst_moved", 32'(moved), 0);
    chk("arst_done", 32'(game_done), 0);
    chk_body("arst");
    #1;
    reset = 1'b0;
    tick();
    step = 1'b1;
    tick();
    step = 1'b0;
    tick();
    tick();
    chk("idle_busy", 32'(busy), 0);
    chk("idle_x0", x_values[31:0], 4);

    do_start();
    while (mlen < MAX_LEN)
      do_step(tour_dir(int'(mx[0]), int'(my[0])), 1, 0, 0);
    chk("full_len", 32'(length), 100);
    do_step(tour_dir(int'(mx[0]), int'(my[0])), 0, 0, 0);
    do_step(tour_dir(int'(mx[0]), int'(my[0])), 0, 1, 0);
    chk("sat_len", 32'(length), 100);
    do_step(tour_dir(int'(mx[0]), int'(my[0])), 1, 0, 0);
    chk("sat_dead_len", 32'(length), 100);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
